// File: rtl/n64_flashram_pkg.sv
// Shared types and constants for the N64 FlashRAM controller: command bytes,
// register-file states, status bit positions and default ID words.
package n64_flashram_pkg;

    typedef enum logic [7:0] {
        CMD_NONE         = 8'h00,
        CMD_STATUS       = 8'hD2,
        CMD_ID           = 8'hE1,
        CMD_READ         = 8'hF0,
        CMD_BUFFER       = 8'hB4,
        CMD_ERASE_SECTOR = 8'h4B,
        CMD_ERASE_CHIP   = 8'h3C,
        CMD_ERASE_EXEC   = 8'h78,
        CMD_WRITE_EXEC   = 8'hA5
    } cmd_e;

    typedef enum logic [1:0] {
        ST_STATUS = 2'd0,
        ST_ID     = 2'd1,
        ST_READ   = 2'd2,
        ST_BUFFER = 2'd3
    } mode_e;

    typedef enum int unsigned {
        STAT_WRITE_BUSY = 0,
        STAT_ERASE_BUSY = 1,
        STAT_WRITE_DONE = 2,
        STAT_ERASE_DONE = 3,
        STAT_ERROR      = 4
    } status_bit_e;

    localparam int unsigned STATUS_W = 5;

    localparam logic [31:0] DEFAULT_TYPE_ID  = 32'h1111_8001;
    localparam logic [31:0] DEFAULT_MODEL_ID = 32'h00C2_001D;

endpackage

// File: rtl/n64_flashram_page_buffer.sv
// FlashRAM page buffer: 32-bit words written one 16-bit half at a time,
// read through a registered port (read-before-write on address collision).
module n64_flashram_page_buffer #(
    parameter int unsigned PAGE_WORDS = 32
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(PAGE_WORDS)-1:0] waddr,
    input  logic                          half_lo,
    input  logic [15:0]                   wdata,
    input  logic [$clog2(PAGE_WORDS)-1:0] raddr,
    output logic [31:0]                   rdata
);

    logic [31:0] mem [PAGE_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            if (half_lo) begin
                mem[waddr][15:0] <= wdata;
            end else begin
                mem[waddr][31:16] <= wdata;
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/n64_flashram_ctrl.sv
// N64 FlashRAM cartridge controller: bus-side command/status interface, page
// buffer and erase/write op handshake. Optional watchdog: FLASHRAM_TIMEOUT_EN.
module n64_flashram_ctrl
    import n64_flashram_pkg::*;
#(
    parameter int unsigned PAGE_WORDS     = 32,
    parameter int unsigned SECTOR_W       = 10,
    parameter logic [31:0] TYPE_ID        = DEFAULT_TYPE_ID,
    parameter logic [31:0] MODEL_ID       = DEFAULT_MODEL_ID,
    parameter int unsigned TIMEOUT_CYCLES = 1 << 24
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          bus_request,
    input  logic                          bus_write,
    input  logic [16:0]                   bus_address,
    input  logic [15:0]                   bus_wdata,
    output logic [15:0]                   bus_rdata,
    output logic                          bus_ack,
    input  logic                          wp,
    output logic                          read_mode,
    output logic                          op_pending,
    output logic                          op_write_or_erase,
    output logic                          op_sector_or_all,
    output logic [SECTOR_W-1:0]           op_sector,
    input  logic                          op_done,
    input  logic [$clog2(PAGE_WORDS)-1:0] buf_address,
    output logic [31:0]                   buf_rdata
);

    localparam int unsigned AW = $clog2(PAGE_WORDS);

    localparam logic [0:0] BUS_IDLE = 1'b0;
    localparam logic [0:0] BUS_WAIT = 1'b1;

    logic [0:0]          bus_state;
    mode_e               mode;
    logic [STATUS_W-1:0] status;
    logic                erase_armed;
    logic [7:0]          command;

    logic                accept;
    logic                wr_ok;
    logic                cmd_latch;
    logic                cmd_exec;
    logic                data_wr;
    logic                buf_we;
    logic                done_evt;
    logic                timeout_evt;
    logic [SECTOR_W-1:0] wdata_sector;

    assign accept       = bus_request && (bus_state == BUS_IDLE);
    // Writes are refused for the whole pending window, including the op_done cycle.
    assign wr_ok        = accept && bus_write && !op_pending;
    assign cmd_latch    = wr_ok && bus_address[16] && !bus_address[1];
    assign cmd_exec     = wr_ok && bus_address[16] && bus_address[1];
    assign data_wr      = wr_ok && !bus_address[16];
    assign buf_we       = data_wr && (mode == ST_BUFFER);
    assign done_evt     = op_pending && op_done;
    assign wdata_sector = SECTOR_W'(bus_wdata);

`ifdef FLASHRAM_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0] timeout_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || !op_pending) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    assign timeout_evt = op_pending && !op_done &&
                         (timeout_cnt == TCW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign timeout_evt    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus_state         <= BUS_IDLE;
            bus_ack           <= 1'b0;
            mode              <= ST_STATUS;
            status            <= '0;
            erase_armed       <= 1'b0;
            command           <= 8'h00;
            op_pending        <= 1'b0;
            op_write_or_erase <= 1'b0;
            op_sector_or_all  <= 1'b0;
            op_sector         <= '0;
        end else begin
            bus_state <= accept ? BUS_WAIT : BUS_IDLE;
            bus_ack   <= accept;

            if (done_evt) begin
                op_pending <= 1'b0;
                if (op_write_or_erase) begin
                    status[STAT_ERASE_BUSY] <= 1'b0;
                    status[STAT_ERASE_DONE] <= 1'b1;
                end else begin
                    status[STAT_WRITE_BUSY] <= 1'b0;
                    status[STAT_WRITE_DONE] <= 1'b1;
                end
            end else if (timeout_evt) begin
                op_pending <= 1'b0;
                status[STAT_ERROR] <= 1'b1;
                if (op_write_or_erase) begin
                    status[STAT_ERASE_BUSY] <= 1'b0;
                end else begin
                    status[STAT_WRITE_BUSY] <= 1'b0;
                end
            end

            if (cmd_latch) begin
                command <= bus_wdata[15:8];
            end

            if (cmd_exec) begin
                erase_armed <= (command == CMD_ERASE_SECTOR) || (command == CMD_ERASE_CHIP);
                case (command)
                    CMD_STATUS: mode <= ST_STATUS;
                    CMD_ID:     mode <= ST_ID;
                    CMD_READ:   mode <= ST_READ;
                    CMD_BUFFER: mode <= ST_BUFFER;
                    CMD_ERASE_SECTOR: begin
                        mode             <= ST_STATUS;
                        op_sector        <= wdata_sector;
                        op_sector_or_all <= 1'b0;
                    end
                    CMD_ERASE_CHIP: begin
                        mode             <= ST_STATUS;
                        op_sector        <= '0;
                        op_sector_or_all <= 1'b1;
                    end
                    CMD_ERASE_EXEC: begin
                        mode <= ST_STATUS;
                        if (erase_armed && !wp) begin
                            status[STAT_ERASE_BUSY] <= 1'b1;
                            status[STAT_ERASE_DONE] <= 1'b0;
                            op_pending              <= 1'b1;
                            op_write_or_erase       <= 1'b1;
                        end else begin
                            status[STAT_ERROR] <= 1'b1;
                        end
                    end
                    CMD_WRITE_EXEC: begin
                        mode <= ST_STATUS;
                        if (!wp) begin
                            status[STAT_WRITE_BUSY] <= 1'b1;
                            status[STAT_WRITE_DONE] <= 1'b0;
                            op_sector               <= wdata_sector;
                            op_pending              <= 1'b1;
                            op_write_or_erase       <= 1'b0;
                            op_sector_or_all        <= 1'b0;
                        end else begin
                            status[STAT_ERROR] <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (data_wr && (mode == ST_STATUS)) begin
                status[STAT_WRITE_DONE] <= bus_wdata[STAT_WRITE_DONE];
                status[STAT_ERASE_DONE] <= bus_wdata[STAT_ERASE_DONE];
                status[STAT_ERROR]      <= bus_wdata[STAT_ERROR];
            end
        end
    end

    always_comb begin
        bus_rdata = '0;
        if (bus_ack) begin
            if (mode == ST_ID) begin
                case (bus_address[2:1])
                    2'd0:    bus_rdata = TYPE_ID[31:16];
                    2'd1:    bus_rdata = TYPE_ID[15:0];
                    2'd2:    bus_rdata = MODEL_ID[31:16];
                    default: bus_rdata = MODEL_ID[15:0];
                endcase
            end else if (bus_address[1]) begin
                bus_rdata = {11'b0, status};
            end
        end
    end

    assign read_mode = (mode == ST_READ);

    n64_flashram_page_buffer #(
        .PAGE_WORDS(PAGE_WORDS)
    ) u_page_buffer (
        .clk    (clk),
        .we     (buf_we),
        .waddr  (bus_address[AW+1:2]),
        .half_lo(bus_address[1]),
        .wdata  (bus_wdata),
        .raddr  (buf_address),
        .rdata  (buf_rdata)
    );

    logic unused_bits;
    assign unused_bits = ^{bus_address[15:AW+2], bus_address[0]};

endmodule

// File: tb/tb_n64_flashram_ctrl.sv
// Self-checking bench for n64_flashram_ctrl; define FLASHRAM_TIMEOUT_EN in
// both the RTL and bench builds to exercise the watchdog with a 16-cycle limit.
module tb_n64_flashram_ctrl;

    localparam int unsigned PW = 32;
    localparam int unsigned SW = 10;
    localparam int unsigned AW = 5;
`ifdef FLASHRAM_TIMEOUT_EN
    localparam int unsigned TO     = 16;
    localparam bit          TO_ON  = 1'b1;
`else
    localparam int unsigned TO     = 1 << 24;
    localparam bit          TO_ON  = 1'b0;
`endif

    localparam int M_STATUS = 0;
    localparam int M_ID     = 1;
    localparam int M_READ   = 2;
    localparam int M_BUF    = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          bus_request = 1'b0;
    logic          bus_write = 1'b0;
    logic [16:0]   bus_address = '0;
    logic [15:0]   bus_wdata = '0;
    logic [15:0]   bus_rdata;
    logic          bus_ack;
    logic          wp = 1'b0;
    logic          read_mode;
    logic          op_pending;
    logic          op_write_or_erase;
    logic          op_sector_or_all;
    logic [SW-1:0] op_sector;
    logic          op_done = 1'b0;
    logic [AW-1:0] buf_address = '0;
    logic [31:0]   buf_rdata;

    int total = 0;
    int bad = 0;
    int pend_cycles = 0;

    n64_flashram_ctrl #(
        .PAGE_WORDS    (PW),
        .SECTOR_W      (SW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus_request      (bus_request),
        .bus_write        (bus_write),
        .bus_address      (bus_address),
        .bus_wdata        (bus_wdata),
        .bus_rdata        (bus_rdata),
        .bus_ack          (bus_ack),
        .wp               (wp),
        .read_mode        (read_mode),
        .op_pending       (op_pending),
        .op_write_or_erase(op_write_or_erase),
        .op_sector_or_all (op_sector_or_all),
        .op_sector        (op_sector),
        .op_done          (op_done),
        .buf_address      (buf_address),
        .buf_rdata        (buf_rdata)
    );

    always #5 clk = ~clk;

    // Reference model state, advanced once per rising edge from the bench inputs.
    bit          m_live = 1'b0;
    bit          m_ack, m_armed, m_pend, m_woe, m_all;
    int          m_mode, m_sector, m_tcnt;
    logic [4:0]  m_status;
    logic [7:0]  m_cmd;
    logic [31:0] m_buf [PW];
    bit   [1:0]  m_bv  [PW];
    logic [31:0] m_rd;
    bit          m_rd_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_rdata(input logic [16:0] a);
        logic [15:0] ids [4];
        ids = '{16'h1111, 16'h8001, 16'h00C2, 16'h001D};
        if (!m_ack) return 16'h0000;
        if (m_mode == M_ID) return ids[a[2:1]];
        return a[1] ? {11'b0, m_status} : 16'h0000;
    endfunction

    always @(posedge clk) begin : model_p
        bit pend0, acc, keep;
        int idx;
        if (!reset_n) begin
            m_live = 1'b1; m_ack = 0; m_armed = 0; m_pend = 0; m_woe = 0; m_all = 0;
            m_mode = M_STATUS; m_sector = 0; m_tcnt = 0; m_status = '0; m_cmd = 8'h00;
            m_rd_ok = 0;
            for (int i = 0; i < PW; i++) m_bv[i] = 2'b00;
        end else begin
            m_rd    = m_buf[buf_address];
            m_rd_ok = (m_bv[buf_address] == 2'b11);
            pend0   = m_pend;
            acc     = bus_request && !m_ack;
            m_ack   = acc;
            if (pend0) begin
                if (op_done) begin
                    m_pend = 0;
                    if (m_woe) begin m_status[1] = 0; m_status[3] = 1; end
                    else       begin m_status[0] = 0; m_status[2] = 1; end
                end else if (TO_ON) begin
                    m_tcnt++;
                    if (m_tcnt == TO) begin
                        m_pend = 0;
                        m_status[4] = 1;
                        if (m_woe) m_status[1] = 0; else m_status[0] = 0;
                    end
                end
            end else begin
                m_tcnt = 0;
            end
            if (acc && bus_write && !pend0) begin
                if (bus_address[16]) begin
                    if (!bus_address[1]) begin
                        m_cmd = bus_wdata[15:8];
                    end else begin
                        keep = 0;
                        case (m_cmd)
                            8'hD2: m_mode = M_STATUS;
                            8'hE1: m_mode = M_ID;
                            8'hF0: m_mode = M_READ;
                            8'hB4: m_mode = M_BUF;
                            8'h4B: begin m_mode = M_STATUS; keep = 1; m_sector = int'(bus_wdata) % (1 << SW); m_all = 0; end
                            8'h3C: begin m_mode = M_STATUS; keep = 1; m_sector = 0; m_all = 1; end
                            8'h78: begin
                                m_mode = M_STATUS;
                                if (m_armed && !wp) begin m_status[1] = 1; m_status[3] = 0; m_pend = 1; m_woe = 1; end
                                else m_status[4] = 1;
                            end
                            8'hA5: begin
                                m_mode = M_STATUS;
                                if (!wp) begin
                                    m_status[0] = 1; m_status[2] = 0; m_pend = 1; m_woe = 0; m_all = 0;
                                    m_sector = int'(bus_wdata) % (1 << SW);
                                end else m_status[4] = 1;
                            end
                            default: ;
                        endcase
                        m_armed = keep;
                    end
                end else if (m_mode == M_STATUS) begin
                    m_status[4:2] = bus_wdata[4:2];
                end else if (m_mode == M_BUF) begin
                    idx = (int'(bus_address) >> 2) % PW;
                    if (bus_address[1]) begin m_buf[idx][15:0]  = bus_wdata; m_bv[idx][0] = 1; end
                    else                begin m_buf[idx][31:16] = bus_wdata; m_bv[idx][1] = 1; end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("bus_ack",    32'(bus_ack),           32'(m_ack));
            check("bus_rdata",  32'(bus_rdata),         32'(exp_rdata(bus_address)));
            check("read_mode",  32'(read_mode),         32'(m_mode == M_READ));
            check("op_pending", 32'(op_pending),        32'(m_pend));
            check("op_woe",     32'(op_write_or_erase), 32'(m_woe));
            check("op_all",     32'(op_sector_or_all),  32'(m_all));
            check("op_sector",  32'(op_sector),         32'(m_sector));
            if (m_rd_ok) check("buf_rdata", buf_rdata, m_rd);
        end
        if (op_pending === 1'b1) pend_cycles++;
    end

    task automatic bus_op(input bit wr, input logic [16:0] a, input logic [15:0] d, output logic [15:0] rd);
        @(negedge clk);
        bus_request = 1'b1; bus_write = wr; bus_address = a; bus_wdata = d;
        @(posedge clk);
        #1 bus_request = 1'b0; bus_write = 1'b0;
        @(negedge clk);
        rd = bus_rdata;
        @(posedge clk);
    endtask

    task automatic wr(input logic [16:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        bus_op(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string name, input logic [16:0] a, input logic [15:0] exp);
        logic [15:0] v;
        bus_op(1'b0, a, 16'h0000, v);
        check(name, 32'(v), 32'(exp));
    endtask

    task automatic cmd(input logic [7:0] c, input logic [15:0] arg);
        wr(17'h10000, {c, 8'h00});
        wr(17'h10002, arg);
    endtask

    task automatic pulse_done;
        @(negedge clk); op_done = 1'b1;
        @(negedge clk); op_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        check("reset_pending", 32'(op_pending), 32'h0);
        rd_chk("reset_status", 17'h00002, 16'h0000);

        cmd(8'hE1, 16'h0000);
        rd_chk("id0", 17'h00000, 16'h1111);
        rd_chk("id1", 17'h00002, 16'h8001);
        rd_chk("id2", 17'h00004, 16'h00C2);
        rd_chk("id3", 17'h00006, 16'h001D);
        cmd(8'hF0, 16'h0000);
        check("read_mode_on", 32'(read_mode), 32'h1);
        cmd(8'hD2, 16'h0000);
        rd_chk("addr1_zero", 17'h00000, 16'h0000);

        cmd(8'h4B, 16'h0005);
        cmd(8'h78, 16'h0000);
        check("erase_pending", 32'(op_pending), 32'h1);
        check("erase_sector", 32'(op_sector), 32'd5);
        check("erase_kind", 32'(op_write_or_erase), 32'h1);
        rd_chk("erase_busy", 17'h00002, 16'h0002);
        pulse_done;
        rd_chk("erase_done", 17'h00002, 16'h0008);
        wr(17'h00000, 16'h0000);
        rd_chk("status_clr", 17'h00002, 16'h0000);

        cmd(8'h78, 16'h0000);
        check("unarmed_pending", 32'(op_pending), 32'h0);
        rd_chk("unarmed_err", 17'h00002, 16'h0010);
        wr(17'h00000, 16'h0000);
        wp = 1'b1;
        cmd(8'h4B, 16'h0009);
        cmd(8'h78, 16'h0000);
        rd_chk("wp_erase_err", 17'h00002, 16'h0010);
        cmd(8'hA5, 16'h0002);
        check("wp_write_pending", 32'(op_pending), 32'h0);
        rd_chk("wp_write_err", 17'h00002, 16'h0010);
        wp = 1'b0;
        wr(17'h00000, 16'h0000);
        rd_chk("err_clr", 17'h00002, 16'h0000);

        cmd(8'h3C, 16'h0123);
        check("chip_all", 32'(op_sector_or_all), 32'h1);
        check("chip_sector", 32'(op_sector), 32'h0);
        cmd(8'h78, 16'h0000);
        check("chip_pending", 32'(op_pending), 32'h1);
        pulse_done;
        rd_chk("chip_done", 17'h00002, 16'h0008);
        wr(17'h00000, 16'h0000);

        // Request held across the WAIT cycle: only the first write lands.
        @(negedge clk);
        bus_request = 1'b1; bus_write = 1'b1; bus_address = 17'h00000; bus_wdata = 16'h0004;
        @(negedge clk);
        bus_wdata = 16'h0008;
        @(negedge clk);
        bus_request = 1'b0; bus_write = 1'b0;
        @(posedge clk);
        rd_chk("wait_ignored", 17'h00002, 16'h0004);
        wr(17'h00000, 16'h0000);

        cmd(8'hB4, 16'h0000);
        wr(17'h00000, 16'hAAAA);
        wr(17'h00002, 16'h5555);
        wr(17'h0007C, 16'h1234);
        wr(17'h0007E, 16'h5678);
        @(negedge clk); buf_address = 5'd0;
        @(negedge clk);
        check("buf_word0", buf_rdata, 32'hAAAA5555);
        buf_address = 5'd31;
        @(negedge clk);
        check("buf_word31", buf_rdata, 32'h12345678);
        buf_address = 5'd0;
        wr(17'h00080, 16'hBEEF);
        @(negedge clk);
        check("buf_wrap", buf_rdata, 32'hBEEF5555);
        cmd(8'hD2, 16'h0000);

        pend_cycles = 0;
        cmd(8'hA5, 16'h0003);
        check("write_sector", 32'(op_sector), 32'd3);
        cmd(8'hE1, 16'h0000);
        repeat (30) @(negedge clk);
`ifdef FLASHRAM_TIMEOUT_EN
        check("timeout_cycles", 32'(pend_cycles), 32'd16);
        rd_chk("timeout_status", 17'h00002, 16'h0010);
`else
        check("no_timeout", 32'(op_pending), 32'h1);
        rd_chk("busy_status", 17'h00002, 16'h0001);
        pulse_done;
        rd_chk("write_done", 17'h00002, 16'h0004);
`endif
        wr(17'h00000, 16'h0000);

        cmd(8'hA5, 16'h0007);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        check("rst_pending", 32'(op_pending), 32'h0);
        pulse_done;
        rd_chk("rst_late_done", 17'h00002, 16'h0000);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
